// File: rtl/row_clear_ctrl.sv
// Clear-phase sequencer for the board RAM: drops full rows, compacts the rest downward, zero-fills the top.
// Optional SCORE_EN macro adds a saturating score accumulator; otherwise score is tied to 0.
module row_clear_ctrl #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 10,
  parameter int unsigned ROW_W = 4
) (
  input  logic             clka,
  input  logic             restart,
  input  logic             start_clear,
  output logic [ROW_W-1:0] rd_addr,
  input  logic [COLS-1:0]  rd_data,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_addr,
  output logic [COLS-1:0]  wr_data,
  output logic             busy,
  output logic             clear_done,
  output logic [ROW_W:0]   lines_cleared,
  output logic [15:0]      score
);

  localparam int unsigned CNT_W = ROW_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_FILL,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   src_q, src_d;
  logic [CNT_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]   cleared_q, cleared_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clka) begin
    if (restart) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cleared_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cleared_q <= cleared_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Write port is decoded in EVAL from the read data, so it is combinational by necessity
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cleared_d = cleared_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state_q)
      S_IDLE: begin
        if (start_clear) begin
          src_d     = '0;
          dst_d     = '0;
          cleared_d = '0;
          busy_d    = 1'b1;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (&rd_data) begin
          cleared_d = cleared_q + CNT_W'(1);
        end else begin
          if (CNT_W'(src_q) != dst_q) begin
            wr_en   = 1'b1;
            wr_addr = dst_q[ROW_W-1:0];
            wr_data = rd_data;
          end
          dst_d = dst_q + CNT_W'(1);
        end
        if (src_q < ROW_W'(ROWS - 1)) begin
          src_d   = src_q + ROW_W'(1);
          state_d = S_READ;
        end else if (dst_d < CNT_W'(ROWS)) begin
          state_d = S_FILL;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_FILL: begin
        wr_en   = 1'b1;
        wr_addr = dst_q[ROW_W-1:0];
        dst_d   = dst_q + CNT_W'(1);
        if (dst_q == CNT_W'(ROWS - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_addr       = src_q;
  assign busy          = busy_q;
  assign clear_done    = done_q;
  assign lines_cleared = cleared_q;

`ifdef SCORE_EN
  logic [15:0] score_q;
  logic [15:0] bonus;
  logic [16:0] score_sum;

  // Points for the pass just finished; four or more lines earn the top award
  always_comb begin
    bonus = 16'd0;
    case (cleared_q)
      CNT_W'(0): bonus = 16'd0;
      CNT_W'(1): bonus = 16'd40;
      CNT_W'(2): bonus = 16'd100;
      CNT_W'(3): bonus = 16'd300;
      default:   bonus = 16'd1200;
    endcase
    score_sum = {1'b0, score_q} + {1'b0, bonus};
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      score_q <= '0;
    end else if (state_q == S_DONE) begin
      score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule
